sram_wb_arbiter: RTL and testbench
==================================

# sram_wb_arbiter

- Two-master Wishbone arbiter that shares the single-port 1024x32 SRAM macro wrapper.
- Master 0 is the Caravel management Wishbone bus; master 1 is a user-side Wishbone master, such as a logic-analyzer or IO-driven debug/DMA engine.
- The block filters master-0 traffic by address window and grants the SRAM round-robin, one transaction at a time.
- A watchdog guards against a slave that never acknowledges.

## Interface
Parameters:
- BASE_ADDR, 32'h3000_0000, window base for master 0.
- ADDR_MASK, 32'hFFFF_F000, bits compared against BASE_ADDR (4 KB = 1024 words).
- TIMEOUT, 255, maximum wait cycles for slave ack (8-bit counter; legal range 1..255).
- ERR_DATA, 32'hDEAD_BEEF, read data returned on timeout.

Ports:
- wb_clk_i  in  1  clock; all logic on rising edge.
- wb_rst_n_i  in  1  reset, synchronous, active-low.
- m0_cyc_i, m0_stb_i, m0_we_i  in  1 each  master-0 control.
- m0_sel_i  in  4  byte selects.
- m0_adr_i, m0_dat_i  in  32 each  address and write data.
- m0_ack_o  out  1  master-0 acknowledge.
- m0_dat_o  out  32  master-0 read data.
- m1_cyc_i, m1_stb_i, m1_we_i, m1_sel_i[4], m1_adr_i[32], m1_dat_i[32]  in  master-1 request, same meaning as master 0.
- m1_ack_o  out  1  master-1 acknowledge.
- m1_dat_o  out  32  master-1 read data.
- s_cyc_o, s_stb_o, s_we_o  out  1 each  to SRAM wrapper.
- s_sel_o  out  4  to SRAM wrapper.
- s_adr_o, s_dat_o  out  32 each  to SRAM wrapper.
- s_ack_i  in  1  from SRAM wrapper.
- s_dat_i  in  32  from SRAM wrapper.
- timeout_o  out  1  one-cycle pulse on watchdog expiry.
- err_sticky_o  out  1  set on any timeout; cleared only by reset.
- gnt_o  out  2  one-hot current grant, for debug and LA.

## Operation
- Request qualification:
  - req0 = m0_cyc_i & m0_stb_i & ((m0_adr_i & ADDR_MASK) == BASE_ADDR).
  - req1 = m1_cyc_i & m1_stb_i; master 1 is not address-filtered.
  - Master-0 cycles outside the window are ignored and never acknowledged here; other Caravel slaves own them.
- State machine states: IDLE, GNT0, GNT1.
  - IDLE: if only one request is asserted, go to that master's GNT state.
  - IDLE with both requests: grant the master that did not complete last. The last_gnt bit resets to 1, so master 0 wins the first tie.
  - GNTx: s_* outputs mirror master x combinationally. s_cyc_o = s_stb_o = mx_cyc_i & mx_stb_i.
  - GNTx on s_ack_i: pass ack to mx_ack_o and s_dat_i to mx_dat_o in the same cycle, set last_gnt = x, go to IDLE.
  - GNTx, master abort (mx_cyc_i falls before ack): go to IDLE next cycle with no ack; last_gnt is still updated to x.
  - GNTx, watchdog: counter clears on entry. It increments each cycle without s_ack_i. When it reaches TIMEOUT, assert mx_ack_o with mx_dat_o = ERR_DATA, pulse timeout_o, set err_sticky_o, drop s_cyc_o/s_stb_o, and go to IDLE.
- Idle and non-granted outputs:
  - Non-granted master: ack = 0, dat = 0.
  - In IDLE: all s_* outputs = 0.
- Between transactions an IDLE cycle is mandatory, so there are no back-to-back grants.
- A late s_ack_i arriving in IDLE is ignored.

## Timing
- Reset (wb_rst_n_i = 0 at a clock edge):
  - State = IDLE, last_gnt = 1, counter = 0, err_sticky_o = 0.
  - All outputs 0, gnt_o = 2'b00.
- Reset asserted mid-transaction aborts it: no ack to the master, and s_cyc_o is low from the next edge.
- Latency, request to slave: a request seen in IDLE at edge N gives s_stb_o high in cycle N+1.
- Ack path: the master ack is combinational from s_ack_i in that cycle. With the SRAM wrapper's 1-cycle ack, total latency is 2 cycles from request to master ack.
- Throughput: at most one transaction per 3 cycles per the mandatory-IDLE rule.
- Timeout: the ack is issued at cycle N+1+TIMEOUT after grant.
- Simultaneous s_ack_i and timeout in the same cycle: the real ack wins; timeout_o is not pulsed.

## Structure
- The shared package holds the state enum (IDLE/GNT0/GNT1), default ERR_DATA, and default window constants.
- One natural sub-module: wb_rr_arb2. It is the 2-way round-robin pick with the last_gnt register, and it is reusable for a future second SRAM macro.
- The mux and watchdog stay in the top level.

## Test plan
- Single read, master 0 at 0x3000_0010, SRAM returns 0x1234_5678 -> s_stb_o high at N+1, m0_ack_o with 0x1234_5678 at N+2, m1_ack_o stays 0.
- Out-of-window: m0 at 0x2000_0000 -> s_cyc_o stays 0 for 300 cycles, no ack, no timeout.
- Contention, both masters requesting every cycle out of reset -> grants alternate m0, m1, m0, m1 over 8 transactions; gnt_o matches; write data and sel reach s_* unaltered.
- Timeout:
  - Slave model never acks, TIMEOUT = 4 -> m1_ack_o with 0xDEAD_BEEF at grant+5, timeout_o high for exactly 1 cycle, err_sticky_o = 1.
  - Next transaction -> completes normally and err_sticky_o stays 1.
- Master abort:
  - m0 drops cyc after 1 granted cycle -> IDLE next cycle, no ack.
  - Pending m1 -> granted next.
- Reset mid-transaction in GNT1 -> all outputs 0 at the next edge; after release, a tie is granted to m0.

Source files
------------

// File: rtl/sram_wb_arbiter_pkg.sv
// Shared constants for the SRAM Wishbone arbiter: FSM encodings, default
// address window, watchdog default and the error read pattern.
package sram_wb_arbiter_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_GNT0 = 2'd1;
  localparam logic [1:0] ST_GNT1 = 2'd2;

  localparam logic [31:0] DEF_BASE_ADDR = 32'h3000_0000;
  localparam logic [31:0] DEF_ADDR_MASK = 32'hFFFF_F000;
  localparam logic [31:0] DEF_ERR_DATA  = 32'hDEAD_BEEF;
  localparam int          DEF_TIMEOUT   = 255;

  function automatic logic in_window(input logic [31:0] adr,
                                     input logic [31:0] base,
                                     input logic [31:0] mask);
    return (adr & mask) == base;
  endfunction

endpackage

// File: rtl/wb_rr_arb2.sv
// Two-way round-robin pick. On a tie the master that did not complete last
// wins; last_q resets to 1 so master 0 wins the first tie.
module wb_rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req_i,
  input  logic       done_i,
  input  logic       done_id_i,
  output logic [1:0] pick_o,
  output logic       last_o
);

  logic last_q;
  logic last_d;

  always_comb begin
    last_d = last_q;
    if (done_i) last_d = done_id_i;
  end

  always_comb begin
    pick_o = 2'b00;
    case (req_i)
      2'b01:   pick_o = 2'b01;
      2'b10:   pick_o = 2'b10;
      2'b11:   pick_o = last_q ? 2'b01 : 2'b10;
      default: pick_o = 2'b00;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) last_q <= 1'b1;
    else        last_q <= last_d;
  end

  assign last_o = last_q;

endmodule

// File: rtl/sram_wb_arbiter.sv
// Two-master Wishbone arbiter in front of the single-port SRAM wrapper, with
// master-0 address filtering, round-robin grant and an ack watchdog.
module sram_wb_arbiter
  import sram_wb_arbiter_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = DEF_BASE_ADDR,
  parameter logic [31:0] ADDR_MASK = DEF_ADDR_MASK,
  parameter int          TIMEOUT   = DEF_TIMEOUT,
  parameter logic [31:0] ERR_DATA  = DEF_ERR_DATA
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_n_i,
  input  logic        m0_cyc_i,
  input  logic        m0_stb_i,
  input  logic        m0_we_i,
  input  logic [3:0]  m0_sel_i,
  input  logic [31:0] m0_adr_i,
  input  logic [31:0] m0_dat_i,
  output logic        m0_ack_o,
  output logic [31:0] m0_dat_o,
  input  logic        m1_cyc_i,
  input  logic        m1_stb_i,
  input  logic        m1_we_i,
  input  logic [3:0]  m1_sel_i,
  input  logic [31:0] m1_adr_i,
  input  logic [31:0] m1_dat_i,
  output logic        m1_ack_o,
  output logic [31:0] m1_dat_o,
  output logic        s_cyc_o,
  output logic        s_stb_o,
  output logic        s_we_o,
  output logic [3:0]  s_sel_o,
  output logic [31:0] s_adr_o,
  output logic [31:0] s_dat_o,
  input  logic        s_ack_i,
  input  logic [31:0] s_dat_i,
  output logic        timeout_o,
  output logic        err_sticky_o,
  output logic [1:0]  gnt_o
);

  localparam logic [7:0] TO_CNT = 8'(TIMEOUT);

  logic [1:0] state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic       err_q, err_d;
  logic [1:0] req, pick;
  logic       last_gnt;
  logic       done, done_id;
  logic       gid, g_cyc, g_ack;
  logic [31:0] g_dat;

  assign req[0] = m0_cyc_i & m0_stb_i & in_window(m0_adr_i, BASE_ADDR, ADDR_MASK);
  assign req[1] = m1_cyc_i & m1_stb_i;

  wb_rr_arb2 u_rr (
    .clk       (wb_clk_i),
    .rst_n     (wb_rst_n_i),
    .req_i     (req),
    .done_i    (done),
    .done_id_i (done_id),
    .pick_o    (pick),
    .last_o    (last_gnt)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    err_d     = err_q;
    done      = 1'b0;
    done_id   = 1'b0;
    gid       = (state_q == ST_GNT1);
    g_cyc     = gid ? m1_cyc_i : m0_cyc_i;
    g_ack     = 1'b0;
    g_dat     = 32'h0;
    timeout_o = 1'b0;
    s_cyc_o   = 1'b0;
    s_stb_o   = 1'b0;
    s_we_o    = 1'b0;
    s_sel_o   = 4'h0;
    s_adr_o   = 32'h0;
    s_dat_o   = 32'h0;
    case (state_q)
      ST_IDLE: begin
        cnt_d = 8'h0;
        if (pick[0])      state_d = ST_GNT0;
        else if (pick[1]) state_d = ST_GNT1;
      end
      ST_GNT0, ST_GNT1: begin
        s_cyc_o = gid ? (m1_cyc_i & m1_stb_i) : (m0_cyc_i & m0_stb_i);
        s_stb_o = s_cyc_o;
        s_we_o  = gid ? m1_we_i  : m0_we_i;
        s_sel_o = gid ? m1_sel_i : m0_sel_i;
        s_adr_o = gid ? m1_adr_i : m0_adr_i;
        s_dat_o = gid ? m1_dat_i : m0_dat_i;
        // Abort beats ack, and a real ack beats the watchdog in the same cycle.
        if (!g_cyc) begin
          done    = 1'b1;
          done_id = gid;
          state_d = ST_IDLE;
        end else if (s_ack_i) begin
          g_ack   = 1'b1;
          g_dat   = s_dat_i;
          done    = 1'b1;
          done_id = gid;
          state_d = ST_IDLE;
        end else if (cnt_q == TO_CNT) begin
          g_ack     = 1'b1;
          g_dat     = ERR_DATA;
          timeout_o = 1'b1;
          err_d     = 1'b1;
          s_cyc_o   = 1'b0;
          s_stb_o   = 1'b0;
          done      = 1'b1;
          done_id   = gid;
          state_d   = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign m0_ack_o     = g_ack & (state_q == ST_GNT0);
  assign m0_dat_o     = (state_q == ST_GNT0) ? g_dat : 32'h0;
  assign m1_ack_o     = g_ack & (state_q == ST_GNT1);
  assign m1_dat_o     = (state_q == ST_GNT1) ? g_dat : 32'h0;
  assign gnt_o        = {state_q == ST_GNT1, state_q == ST_GNT0};
  assign err_sticky_o = err_q;

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_n_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= 8'h0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_sram_wb_arbiter.sv
// Directed self-checking bench for sram_wb_arbiter with a 1-cycle-ack SRAM
// slave model and a watchdog of 4 cycles.
module tb_sram_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        m0_cyc, m0_stb, m0_we;
  logic [3:0]  m0_sel;
  logic [31:0] m0_adr, m0_wdat;
  logic        m0_ack;
  logic [31:0] m0_rdat;
  logic        m1_cyc, m1_stb, m1_we;
  logic [3:0]  m1_sel;
  logic [31:0] m1_adr, m1_wdat;
  logic        m1_ack;
  logic [31:0] m1_rdat;
  logic        s_cyc, s_stb, s_we;
  logic [3:0]  s_sel;
  logic [31:0] s_adr, s_dat;
  logic        s_ack;
  logic [31:0] s_rdat;
  logic        timeout, err_sticky;
  logic [1:0]  gnt;

  logic        slv_en, slv_force, slv_ack;
  logic [31:0] slv_rdata;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  sram_wb_arbiter #(
    .BASE_ADDR (32'h3000_0000),
    .ADDR_MASK (32'hFFFF_F000),
    .TIMEOUT   (4),
    .ERR_DATA  (32'hDEAD_BEEF)
  ) dut (
    .wb_clk_i     (clk),
    .wb_rst_n_i   (rst_n),
    .m0_cyc_i     (m0_cyc),
    .m0_stb_i     (m0_stb),
    .m0_we_i      (m0_we),
    .m0_sel_i     (m0_sel),
    .m0_adr_i     (m0_adr),
    .m0_dat_i     (m0_wdat),
    .m0_ack_o     (m0_ack),
    .m0_dat_o     (m0_rdat),
    .m1_cyc_i     (m1_cyc),
    .m1_stb_i     (m1_stb),
    .m1_we_i      (m1_we),
    .m1_sel_i     (m1_sel),
    .m1_adr_i     (m1_adr),
    .m1_dat_i     (m1_wdat),
    .m1_ack_o     (m1_ack),
    .m1_dat_o     (m1_rdat),
    .s_cyc_o      (s_cyc),
    .s_stb_o      (s_stb),
    .s_we_o       (s_we),
    .s_sel_o      (s_sel),
    .s_adr_o      (s_adr),
    .s_dat_o      (s_dat),
    .s_ack_i      (s_ack),
    .s_dat_i      (s_rdat),
    .timeout_o    (timeout),
    .err_sticky_o (err_sticky),
    .gnt_o        (gnt)
  );

  // SRAM wrapper model: ack one cycle after a strobe is seen.
  always @(posedge clk) begin
    if (!rst_n) slv_ack <= 1'b0;
    else        slv_ack <= slv_en & s_cyc & s_stb & ~slv_ack;
  end
  assign s_ack  = slv_ack | slv_force;
  assign s_rdat = slv_rdata;

  initial begin
    #200000;
    $display("FAIL global_timeout: got running exp finished");
    $fatal(1, "simulation time limit");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic m0_req(input logic [31:0] adr, input logic we, input logic [31:0] dat, input logic [3:0] sel);
    m0_cyc = 1'b1; m0_stb = 1'b1; m0_we = we; m0_adr = adr; m0_wdat = dat; m0_sel = sel;
  endtask

  task automatic m1_req(input logic [31:0] adr, input logic we, input logic [31:0] dat, input logic [3:0] sel);
    m1_cyc = 1'b1; m1_stb = 1'b1; m1_we = we; m1_adr = adr; m1_wdat = dat; m1_sel = sel;
  endtask

  task automatic m0_drop;
    m0_cyc = 1'b0; m0_stb = 1'b0; m0_we = 1'b0; m0_adr = 32'h0; m0_wdat = 32'h0; m0_sel = 4'h0;
  endtask

  task automatic m1_drop;
    m1_cyc = 1'b0; m1_stb = 1'b0; m1_we = 1'b0; m1_adr = 32'h0; m1_wdat = 32'h0; m1_sel = 4'h0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; slv_en = 1'b1; slv_force = 1'b0; slv_rdata = 32'h0;
    m0_drop; m1_drop;
    m0_req(32'h3000_0004, 1'b0, 32'h0, 4'hF);
    tick; tick; tick;
    checks++; if (gnt !== 2'b00) begin failures++; $display("FAIL reset_gnt: got %b exp 00", gnt); end
    checks++; if (s_cyc !== 1'b0 || s_stb !== 1'b0) begin failures++; $display("FAIL reset_s_cyc: got %b%b exp 00", s_cyc, s_stb); end
    checks++; if ({m0_ack, m1_ack, timeout} !== 3'b000) begin failures++; $display("FAIL reset_acks: got %b exp 000", {m0_ack, m1_ack, timeout}); end
    checks++; if (err_sticky !== 1'b0) begin failures++; $display("FAIL reset_err: got %b exp 0", err_sticky); end
    checks++; if (s_adr !== 32'h0 || m0_rdat !== 32'h0) begin failures++; $display("FAIL reset_data: got %h/%h exp 0/0", s_adr, m0_rdat); end
    m0_drop;
    rst_n = 1'b1;
    tick;
  endtask

  task automatic test_single_read;
    slv_en = 1'b1; slv_rdata = 32'h1234_5678;
    m0_req(32'h3000_0010, 1'b0, 32'h0, 4'hF);
    #1;
    checks++; if (s_stb !== 1'b0) begin failures++; $display("FAIL rd_pre_stb: got %b exp 0", s_stb); end
    tick;
    checks++; if (s_stb !== 1'b1 || gnt !== 2'b01) begin failures++; $display("FAIL rd_stb_n1: got stb=%b gnt=%b exp 1/01", s_stb, gnt); end
    checks++; if (s_adr !== 32'h3000_0010 || m0_ack !== 1'b0) begin failures++; $display("FAIL rd_adr_n1: got %h ack=%b exp 30000010/0", s_adr, m0_ack); end
    tick;
    checks++; if (m0_ack !== 1'b1 || m0_rdat !== 32'h1234_5678) begin failures++; $display("FAIL rd_ack_n2: got ack=%b dat=%h exp 1/12345678", m0_ack, m0_rdat); end
    checks++; if (m1_ack !== 1'b0 || m1_rdat !== 32'h0) begin failures++; $display("FAIL rd_m1_quiet: got ack=%b dat=%h exp 0/0", m1_ack, m1_rdat); end
    tick;
    m0_drop;
    #1;
    checks++; if (gnt !== 2'b00 || m0_ack !== 1'b0) begin failures++; $display("FAIL rd_idle_after: got gnt=%b ack=%b exp 00/0", gnt, m0_ack); end
  endtask

  task automatic test_out_of_window;
    int bad_cyc = 0;
    int bad_ack = 0;
    int bad_to = 0;
    m0_req(32'h2000_0000, 1'b0, 32'h0, 4'hF);
    for (int i = 0; i < 300; i++) begin
      tick;
      if (s_cyc !== 1'b0) bad_cyc++;
      if (m0_ack !== 1'b0) bad_ack++;
      if (timeout !== 1'b0) bad_to++;
    end
    checks++; if (bad_cyc !== 0) begin failures++; $display("FAIL oow_s_cyc: got %0d cycles exp 0", bad_cyc); end
    checks++; if (bad_ack !== 0) begin failures++; $display("FAIL oow_ack: got %0d cycles exp 0", bad_ack); end
    checks++; if (bad_to !== 0 || err_sticky !== 1'b0) begin failures++; $display("FAIL oow_timeout: got %0d/%b exp 0/0", bad_to, err_sticky); end
    m0_drop;
    tick;
  endtask

  task automatic test_contention;
    int n0 = 0;
    int n1 = 0;
    int k;
    logic exp_m;
    logic [31:0] exp_dat, exp_adr;
    logic [3:0] exp_sel;
    logic [1:0] exp_gnt;
    rst_n = 1'b0; tick; rst_n = 1'b1;
    slv_en = 1'b1; slv_rdata = 32'h0;
    m0_req(32'h3000_0020, 1'b1, 32'hA000_0000, 4'h3);
    m1_req(32'h0000_0100, 1'b1, 32'hB000_0000, 4'hC);
    for (int t = 0; t < 8; t++) begin
      exp_m   = (t % 2) == 1;
      exp_gnt = exp_m ? 2'b10 : 2'b01;
      exp_dat = exp_m ? 32'hB000_0000 + 32'(n1) : 32'hA000_0000 + 32'(n0);
      exp_adr = exp_m ? 32'h0000_0100 : 32'h3000_0020;
      exp_sel = exp_m ? 4'hC : 4'h3;
      k = 0;
      while (gnt === 2'b00 && k < 10) begin tick; k++; end
      checks++; if (gnt !== exp_gnt) begin failures++; $display("FAIL cont_gnt[%0d]: got %b exp %b", t, gnt, exp_gnt); end
      checks++; if (s_dat !== exp_dat || s_sel !== exp_sel) begin failures++; $display("FAIL cont_wdata[%0d]: got %h/%h exp %h/%h", t, s_dat, s_sel, exp_dat, exp_sel); end
      checks++; if (s_adr !== exp_adr || s_we !== 1'b1) begin failures++; $display("FAIL cont_adr[%0d]: got %h/%b exp %h/1", t, s_adr, s_we, exp_adr); end
      tick;
      checks++; if ({m1_ack, m0_ack} !== exp_gnt) begin failures++; $display("FAIL cont_ack[%0d]: got %b exp %b", t, {m1_ack, m0_ack}, exp_gnt); end
      tick;
      if (exp_m) begin n1++; m1_wdat = 32'hB000_0000 + 32'(n1); end
      else       begin n0++; m0_wdat = 32'hA000_0000 + 32'(n0); end
    end
    m0_drop; m1_drop;
    tick;
  endtask

  task automatic test_timeout;
    slv_en = 1'b0;
    m1_req(32'h0000_0040, 1'b0, 32'h0, 4'hF);
    tick;
    checks++; if (gnt !== 2'b10 || m1_ack !== 1'b0) begin failures++; $display("FAIL to_grant: got gnt=%b ack=%b exp 10/0", gnt, m1_ack); end
    for (int i = 1; i <= 3; i++) begin
      tick;
      checks++; if (m1_ack !== 1'b0 || timeout !== 1'b0) begin failures++; $display("FAIL to_wait[%0d]: got ack=%b to=%b exp 0/0", i, m1_ack, timeout); end
    end
    tick;
    checks++; if (m1_ack !== 1'b1 || m1_rdat !== 32'hDEAD_BEEF) begin failures++; $display("FAIL to_ack: got ack=%b dat=%h exp 1/deadbeef", m1_ack, m1_rdat); end
    checks++; if (timeout !== 1'b1 || s_cyc !== 1'b0 || s_stb !== 1'b0) begin failures++; $display("FAIL to_pulse: got to=%b cyc=%b stb=%b exp 1/0/0", timeout, s_cyc, s_stb); end
    tick;
    m1_drop;
    checks++; if (timeout !== 1'b0 || err_sticky !== 1'b1 || m1_ack !== 1'b0) begin failures++; $display("FAIL to_after: got to=%b err=%b ack=%b exp 0/1/0", timeout, err_sticky, m1_ack); end
    slv_en = 1'b1; slv_rdata = 32'h5555_AAAA;
    m1_req(32'h0000_0044, 1'b0, 32'h0, 4'hF);
    tick; tick;
    checks++; if (m1_ack !== 1'b1 || m1_rdat !== 32'h5555_AAAA || timeout !== 1'b0) begin failures++; $display("FAIL to_next_txn: got ack=%b dat=%h to=%b exp 1/5555aaaa/0", m1_ack, m1_rdat, timeout); end
    tick;
    m1_drop;
    checks++; if (err_sticky !== 1'b1) begin failures++; $display("FAIL to_sticky_kept: got %b exp 1", err_sticky); end
  endtask

  task automatic test_ack_vs_timeout;
    slv_en = 1'b0; slv_rdata = 32'h0BAD_F00D;
    m1_req(32'h0000_0048, 1'b0, 32'h0, 4'hF);
    tick; tick; tick; tick; tick;
    slv_force = 1'b1;
    #1;
    checks++; if (m1_ack !== 1'b1 || m1_rdat !== 32'h0BAD_F00D) begin failures++; $display("FAIL race_ack: got ack=%b dat=%h exp 1/0badf00d", m1_ack, m1_rdat); end
    checks++; if (timeout !== 1'b0) begin failures++; $display("FAIL race_no_pulse: got %b exp 0", timeout); end
    tick;
    m1_drop;
    #1;
    checks++; if (gnt !== 2'b00 || m1_ack !== 1'b0 || m0_ack !== 1'b0) begin failures++; $display("FAIL late_ack_idle: got gnt=%b acks=%b%b exp 00/00", gnt, m1_ack, m0_ack); end
    tick;
    checks++; if (gnt !== 2'b00 || s_cyc !== 1'b0) begin failures++; $display("FAIL late_ack_stay: got gnt=%b cyc=%b exp 00/0", gnt, s_cyc); end
    slv_force = 1'b0;
    tick;
  endtask

  task automatic test_abort;
    slv_en = 1'b0; slv_rdata = 32'h7777_0001;
    m0_req(32'h3000_0030, 1'b0, 32'h0, 4'hF);
    m1_req(32'h0000_0050, 1'b0, 32'h0, 4'hF);
    tick;
    checks++; if (gnt !== 2'b01) begin failures++; $display("FAIL abort_grant0: got %b exp 01", gnt); end
    tick;
    m0_drop;
    #1;
    checks++; if (s_cyc !== 1'b0 || m0_ack !== 1'b0) begin failures++; $display("FAIL abort_drop: got cyc=%b ack=%b exp 0/0", s_cyc, m0_ack); end
    slv_en = 1'b1;
    tick;
    checks++; if (gnt !== 2'b00 || m0_ack !== 1'b0) begin failures++; $display("FAIL abort_idle: got gnt=%b ack=%b exp 00/0", gnt, m0_ack); end
    tick;
    checks++; if (gnt !== 2'b10) begin failures++; $display("FAIL abort_m1_next: got %b exp 10", gnt); end
    tick;
    checks++; if (m1_ack !== 1'b1 || m1_rdat !== 32'h7777_0001) begin failures++; $display("FAIL abort_m1_ack: got ack=%b dat=%h exp 1/77770001", m1_ack, m1_rdat); end
    tick;
    m1_drop;
    tick;
  endtask

  task automatic test_reset_mid;
    // m0 completes first so that, absent reset, the next tie would go to m1.
    slv_en = 1'b1; slv_rdata = 32'h0;
    m0_req(32'h3000_0040, 1'b0, 32'h0, 4'hF);
    tick; tick; tick;
    m0_drop;
    slv_en = 1'b0;
    m1_req(32'h0000_0060, 1'b1, 32'hCAFE_0000, 4'hF);
    tick;
    checks++; if (gnt !== 2'b10) begin failures++; $display("FAIL rstmid_grant1: got %b exp 10", gnt); end
    tick;
    m0_req(32'h3000_0044, 1'b0, 32'h0, 4'hF);
    rst_n = 1'b0;
    tick;
    checks++; if (gnt !== 2'b00 || s_cyc !== 1'b0 || s_dat !== 32'h0) begin failures++; $display("FAIL rstmid_outs: got gnt=%b cyc=%b dat=%h exp 00/0/0", gnt, s_cyc, s_dat); end
    checks++; if ({m0_ack, m1_ack, err_sticky} !== 3'b000) begin failures++; $display("FAIL rstmid_flags: got %b exp 000", {m0_ack, m1_ack, err_sticky}); end
    rst_n = 1'b1;
    slv_en = 1'b1;
    tick;
    checks++; if (gnt !== 2'b01) begin failures++; $display("FAIL rstmid_tie_m0: got %b exp 01", gnt); end
    tick;
    checks++; if (m0_ack !== 1'b1 || m1_ack !== 1'b0) begin failures++; $display("FAIL rstmid_m0_ack: got %b%b exp 10", m0_ack, m1_ack); end
    m0_drop; m1_drop;
    tick;
  endtask

  initial begin
    test_reset;
    test_single_read;
    test_out_of_window;
    test_contention;
    test_timeout;
    test_ack_vs_timeout;
    test_abort;
    test_reset_mid;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
